// File: rtl/hex_pe_sequencer.sv
// Operand/result sequencer for a single 16-lane MAC PE: feeds beats, times PE_reset/PE_finish,
// and turns PE valid pulses into an indexed result stream.
module hex_pe_sequencer #(
  parameter int unsigned TREE_LAT = 4,
  parameter int unsigned TILE_W   = 8,
  parameter int unsigned OUT_W    = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [TILE_W-1:0]   cfg_num_tiles,
  input  logic [OUT_W-1:0]    cfg_num_outputs,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [127:0]        op_ifm,
  input  logic [127:0]        op_wgt,
  output logic [127:0]        pe_ifm,
  output logic [127:0]        pe_wgt,
  output logic                pe_reset,
  output logic                pe_finish,
  input  logic [7:0]          pe_ofm,
  input  logic                pe_valid,
  output logic                res_valid,
  output logic [7:0]          res_data,
  output logic [OUT_W-1:0]    res_idx,
  output logic                busy,
  output logic                done,
  output logic                err_seq
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } tok_t;

  state_t                     state;
  logic [TILE_W-1:0]          num_tiles;
  logic [TILE_W-1:0]          tile_cnt;
  logic [OUT_W-1:0]           num_outs;
  logic [OUT_W-1:0]           out_cnt;
  logic [OUT_W-1:0]           fin_cnt;
  logic [OUT_W-1:0]           res_cnt;
  tok_t [TREE_LAT-1:0]        tok;
  tok_t                       tok_in;
  logic                       exp_q;
  logic                       accept;
  logic                       tile_last;
  logic                       out_last;
  logic                       pipe_busy;
  logic                       drain_exit;

  assign op_ready  = (state == S_RUN);
  assign accept    = op_valid && op_ready;
  // Bubbles present zero operands so the PE accumulator adds nothing.
  assign pe_ifm    = accept ? op_ifm : '0;
  assign pe_wgt    = accept ? op_wgt : '0;
  assign tile_last = (tile_cnt == num_tiles - TILE_W'(1));
  assign out_last  = (out_cnt == num_outs - OUT_W'(1));
  assign pe_reset  = tok[TREE_LAT-1].v && tok[TREE_LAT-1].first;
  assign pe_finish = tok[TREE_LAT-1].v && tok[TREE_LAT-1].last;

  assign tok_in = '{v: accept, first: (tile_cnt == '0), last: tile_last};

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < TREE_LAT; i++) pipe_busy = pipe_busy | tok[i].v;
  end

  // After a sequencing error the result count may never be reached; leave once all finishes have drained.
  assign drain_exit = (res_cnt == num_outs) ||
                      (err_seq && (fin_cnt == num_outs) && !exp_q && !pipe_busy);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      num_tiles <= '0;
      num_outs  <= '0;
      tile_cnt  <= '0;
      out_cnt   <= '0;
      fin_cnt   <= '0;
      res_cnt   <= '0;
      tok       <= '0;
      exp_q     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_seq   <= 1'b0;
    end else begin
      done      <= 1'b0;
      res_valid <= 1'b0;
      tok       <= {tok[TREE_LAT-2:0], tok_in};
      exp_q     <= pe_finish;

      if (pe_finish) fin_cnt <= fin_cnt + OUT_W'(1);

      if (pe_valid && exp_q) begin
        res_valid <= 1'b1;
        res_data  <= pe_ofm;
        res_idx   <= res_cnt;
        res_cnt   <= res_cnt + OUT_W'(1);
      end else if (pe_valid != exp_q) begin
        err_seq <= 1'b1;
      end

      if (accept) begin
        tile_cnt <= tile_last ? '0 : tile_cnt + TILE_W'(1);
        if (tile_last) out_cnt <= out_cnt + OUT_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            num_tiles <= cfg_num_tiles;
            num_outs  <= cfg_num_outputs;
            tile_cnt  <= '0;
            out_cnt   <= '0;
            fin_cnt   <= '0;
            res_cnt   <= '0;
            err_seq   <= 1'b0;
            if ((cfg_num_tiles != '0) && (cfg_num_outputs != '0)) begin
              state <= S_RUN;
              busy  <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept && tile_last && out_last) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_exit) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_pe_sequencer.sv
// Bench for hex_pe_sequencer: behavioural PE model, queue-based result scoreboard and latency checks.
module tb_hex_pe_sequencer;

  localparam int unsigned TREE_LAT = 4;
  localparam int unsigned TILE_W   = 8;
  localparam int unsigned OUT_W    = 12;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [TILE_W-1:0]  cfg_num_tiles = '0;
  logic [OUT_W-1:0]   cfg_num_outputs = '0;
  logic               op_valid = 1'b0;
  logic               op_ready;
  logic [127:0]       op_ifm = '0;
  logic [127:0]       op_wgt = '0;
  logic [127:0]       pe_ifm;
  logic [127:0]       pe_wgt;
  logic               pe_reset;
  logic               pe_finish;
  logic [7:0]         pe_ofm;
  logic               pe_valid;
  logic               res_valid;
  logic [7:0]         res_data;
  logic [OUT_W-1:0]   res_idx;
  logic               busy;
  logic               done;
  logic               err_seq;

  hex_pe_sequencer #(.TREE_LAT(TREE_LAT), .TILE_W(TILE_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_num_tiles(cfg_num_tiles), .cfg_num_outputs(cfg_num_outputs),
    .op_valid(op_valid), .op_ready(op_ready), .op_ifm(op_ifm), .op_wgt(op_wgt),
    .pe_ifm(pe_ifm), .pe_wgt(pe_wgt), .pe_reset(pe_reset), .pe_finish(pe_finish),
    .pe_ofm(pe_ofm), .pe_valid(pe_valid),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
    .busy(busy), .done(done), .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dot(input logic [127:0] a, input logic [127:0] b);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < 16; i++) s = s + 8'(a[8*i +: 8] * b[8*i +: 8]);
    return s;
  endfunction

  // PE model: TREE_LAT-stage tree pipeline feeding an 8-bit accumulator.
  logic [7:0] tree [TREE_LAT];
  logic [7:0] acc, pe_ofm_m, nacc;
  logic       pe_valid_m;
  logic       inj = 1'b0;

  assign nacc     = (pe_reset ? 8'd0 : acc) + tree[TREE_LAT-1];
  assign pe_valid = pe_valid_m | inj;
  assign pe_ofm   = pe_ofm_m;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < TREE_LAT; i++) tree[i] <= 8'd0;
      acc        <= 8'd0;
      pe_ofm_m   <= 8'd0;
      pe_valid_m <= 1'b0;
    end else begin
      tree[0] <= dot(pe_ifm, pe_wgt);
      for (int i = 1; i < TREE_LAT; i++) tree[i] <= tree[i-1];
      acc        <= nacc;
      pe_ofm_m   <= nacc;
      pe_valid_m <= pe_finish;
    end
  end

  typedef struct {
    logic [OUT_W-1:0] idx;
    logic [7:0]       data;
  } exp_t;

  exp_t sb[$];

  int acc_cyc = 0, rst_cyc = 0, fin_cyc = 0, res_cyc = 0, res0_cyc = 0, done_cyc = 0;
  int rst_cnt = 0, fin_cnt = 0, res_cnt = 0, done_cnt = 0, rdy_cnt = 0;
  int start_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (op_valid && op_ready) begin
        acc_cyc <= cyc;
        check_eq("pe_ifm_pass", pe_ifm, op_ifm);
        check_eq("pe_wgt_pass", pe_wgt, op_wgt);
      end
      if (busy && !op_valid) begin
        check_eq("pe_ifm_bubble", pe_ifm, 128'd0);
        check_eq("pe_wgt_bubble", pe_wgt, 128'd0);
      end
      if (pe_reset)  begin rst_cnt <= rst_cnt + 1; rst_cyc <= cyc; end
      if (pe_finish) begin fin_cnt <= fin_cnt + 1; fin_cyc <= cyc; end
      if (op_ready)  rdy_cnt <= rdy_cnt + 1;
      if (done)      begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (res_valid) begin
        res_cnt <= res_cnt + 1;
        res_cyc <= cyc;
        if (res_idx == '0) res0_cyc <= cyc;
        check_eq("sb_nonempty", 128'(sb.size() != 0), 128'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("res_data", res_data, e.data);
          check_eq("res_idx", res_idx, e.idx);
        end
      end
    end
  end

  task automatic start_job(input int tiles, input int outs);
    cfg_num_tiles   = TILE_W'(tiles);
    cfg_num_outputs = OUT_W'(outs);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start           = 1'b0;
    cfg_num_tiles   = '1;
    cfg_num_outputs = '1;
  endtask

  task automatic send_beat(input logic [127:0] a, input logic [127:0] b);
    int n;
    n = 0;
    op_ifm   = a;
    op_wgt   = b;
    op_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!op_ready && n < 200);
    if (!op_ready) check_eq("beat_accept_timeout", 128'(op_ready), 128'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int tiles, input int outs, input logic [7:0] iv, input logic [7:0] wv,
                         input int bubble, input bit rnd);
    logic [127:0] a, b;
    logic [7:0]   s;
    start_job(tiles, outs);
    for (int o = 0; o < outs; o++) begin
      s = 8'd0;
      for (int t = 0; t < tiles; t++) begin
        for (int l = 0; l < 16; l++) begin
          a[8*l +: 8] = rnd ? 8'($urandom) : iv;
          b[8*l +: 8] = rnd ? 8'($urandom) : wv;
        end
        s = s + dot(a, b);
        send_beat(a, b);
        if (bubble > 0) begin
          op_valid = 1'b0;
          repeat (bubble) @(posedge clk);
          #1;
        end
      end
      sb.push_back('{idx: OUT_W'(o), data: s});
    end
    op_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check_eq("done_seen", 128'(done), 128'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0, r0, f0, q0, y0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check_eq("rst_res_valid", res_valid, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_op_ready", op_ready, 1'b0);
    check_eq("rst_err_seq", err_seq, 1'b0);
    check_eq("rst_pe_reset", pe_reset, 1'b0);
    check_eq("rst_pe_finish", pe_finish, 1'b0);
    check_eq("rst_res_idx", res_idx, '0);
    @(posedge clk); #1;

    // T1: single beat, single output; latency landmarks
    d0 = done_cnt;
    run_job(1, 1, 8'd1, 8'd2, 0, 1'b0);
    wait_done(40);
    check_eq("t1_rst_lat", 128'(rst_cyc - acc_cyc), 128'd4);
    check_eq("t1_fin_lat", 128'(fin_cyc - acc_cyc), 128'd4);
    check_eq("t1_res_lat", 128'(res_cyc - acc_cyc), 128'd6);
    check_eq("t1_done_lat", 128'(done_cyc - acc_cyc), 128'd7);
    check_eq("t1_done_cnt", 128'(done_cnt - d0), 128'd1);
    check_eq("t1_busy_after", busy, 1'b0);

    // T2: bubbles between beats
    d0 = done_cnt; r0 = res_cnt;
    run_job(3, 2, 8'd1, 8'd1, 2, 1'b0);
    wait_done(80);
    check_eq("t2_res_cnt", 128'(res_cnt - r0), 128'd2);
    check_eq("t2_done_cnt", 128'(done_cnt - d0), 128'd1);

    // T3: tiles=1, back-to-back outputs with wrapping sums
    r0 = res_cnt;
    run_job(1, 4, 8'd3, 8'd7, 0, 1'b0);
    wait_done(60);
    check_eq("t3_res_cnt", 128'(res_cnt - r0), 128'd4);
    check_eq("t3_res_consec", 128'(res_cyc - res0_cyc), 128'd3);

    // Random-data job with bubbles
    r0 = res_cnt;
    run_job(5, 3, 8'd0, 8'd0, 1, 1'b1);
    wait_done(200);
    check_eq("rnd_res_cnt", 128'(res_cnt - r0), 128'd3);

    // T4: zero tiles -> immediate done, no PE activity
    d0 = done_cnt; r0 = res_cnt; f0 = fin_cnt; q0 = rst_cnt; y0 = rdy_cnt;
    start_job(0, 5);
    wait_done(5);
    check_eq("t4_done_lat", 128'(done_cyc - start_cyc), 128'd1);
    check_eq("t4_done_cnt", 128'(done_cnt - d0), 128'd1);
    check_eq("t4_no_res", 128'(res_cnt - r0), 128'd0);
    check_eq("t4_no_fin", 128'(fin_cnt - f0), 128'd0);
    check_eq("t4_no_rst", 128'(rst_cnt - q0), 128'd0);
    check_eq("t4_no_ready", 128'(rdy_cnt - y0), 128'd0);

    // T5: reset mid-job discards it
    start_job(4, 3);
    for (int i = 0; i < 5; i++) send_beat({16{8'd2}}, {16{8'd3}});
    op_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    sb.delete();
    check_eq("t5_busy_rst", busy, 1'b0);
    check_eq("t5_ready_rst", op_ready, 1'b0);
    d0 = done_cnt; r0 = res_cnt;
    repeat (20) @(posedge clk);
    #1;
    check_eq("t5_no_res", 128'(res_cnt - r0), 128'd0);
    check_eq("t5_no_done", 128'(done_cnt - d0), 128'd0);
    run_job(4, 3, 8'd0, 8'd0, 0, 1'b1);
    wait_done(100);
    check_eq("t5_new_res", 128'(res_cnt - r0), 128'd3);
    check_eq("t5_new_done", 128'(done_cnt - d0), 128'd1);

    // T6: spurious pe_valid sets sticky error; start while busy is ignored
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    check_eq("t6_err_set", err_seq, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("t6_err_sticky", err_seq, 1'b1);
    d0 = done_cnt; r0 = res_cnt;
    fork
      run_job(2, 2, 8'd5, 8'd3, 0, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1;
        cfg_num_tiles   = TILE_W'(1);
        cfg_num_outputs = OUT_W'(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_done(60);
    check_eq("t6_err_cleared", err_seq, 1'b0);
    check_eq("t6_res_cnt", 128'(res_cnt - r0), 128'd2);
    check_eq("t6_done_cnt", 128'(done_cnt - d0), 128'd1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("sb_drained", 128'(sb.size()), 128'd0);
    check_eq("idle_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got %0d expected 0", cyc);
    $fatal(1, "timeout");
  end

endmodule
